pll_lock_sequencer: RTL



---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/pll_lock_sequencer_sync2.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_RETRY_MAX     = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Two-flop synchronizer with synchronous active-high clear.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/relock sequencer in the refclk domain; holds core reset until lock is stable.
// Define PLL_SEQ_LOSS_STATS_EN to add loss_count/timeout_total statistics outputs.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned RETRY_MAX     = DEF_RETRY_MAX
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state_o
`ifdef PLL_SEQ_LOSS_STATS_EN
  ,
  output logic [7:0] loss_count,
  output logic [7:0] timeout_total
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);

  state_t         state, nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [RW-1:0]  retry, retry_nxt;
  logic           locked_s;

  sync2 u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // relock_req outranks lock-driven moves; in RUN both lead to the same exit.
  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    case (state)
      PLL_RESET: begin
        if (relock_req)
          cnt_nxt = '0;
        else if (cnt == CW'(RST_CYCLES - 1)) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else
          cnt_nxt = cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          nxt     = PLL_RESET;
          cnt_nxt = '0;
        end else if (locked_s) begin
          nxt     = STABLE;
          cnt_nxt = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_nxt = retry + 1'b1;
          cnt_nxt   = '0;
          nxt       = (retry == RW'(RETRY_MAX - 1)) ? FAIL : PLL_RESET;
        end else
          cnt_nxt = cnt + 1'b1;
      end
      STABLE: begin
        if (relock_req) begin
          nxt     = PLL_RESET;
          cnt_nxt = '0;
        end else if (!locked_s) begin
          nxt     = WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          nxt       = RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else
          cnt_nxt = cnt + 1'b1;
      end
      RUN: begin
        if (relock_req || !locked_s) begin
          nxt     = PLL_RESET;
          cnt_nxt = '0;
        end
      end
      FAIL: begin
        if (relock_req) begin
          nxt       = PLL_RESET;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        nxt     = PLL_RESET;
        cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state   <= PLL_RESET;
      cnt     <= '0;
      retry   <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      retry   <= retry_nxt;
      pll_rst <= (nxt == PLL_RESET) || (nxt == FAIL);
      sys_rst <= (nxt != RUN);
      ready   <= (nxt == RUN);
      fail    <= (nxt == FAIL);
    end
  end

  assign state_o = state;

`ifdef PLL_SEQ_LOSS_STATS_EN
  logic loss_exit, timeout_hit;

  assign loss_exit   = (state == RUN) && !locked_s;
  assign timeout_hit = (state == WAIT_LOCK) && !relock_req && !locked_s &&
                       (cnt == CW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_count    <= 8'd0;
      timeout_total <= 8'd0;
    end else begin
      if (loss_exit && loss_count != 8'hFF)
        loss_count <= loss_count + 8'd1;
      if (timeout_hit && timeout_total != 8'hFF)
        timeout_total <= timeout_total + 8'd1;
    end
  end
`endif

endmodule
